// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module : pwm_multi_channel
// Desc   : N-channel PWM with shared prescaler/counter, period strobe and
//          register readback. Optional macro PWM_SHADOW_EN double-buffers duty
//          so that new values commit only at the counter wrap.
// Rev    : 1.0  initial release
// ============================================================================
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we_i,
  input  logic                      cfg_re_i,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch_i,
  input  logic [1:0]                cfg_sel_i,
  input  logic [CNT_W-1:0]          cfg_wdata_i,
  output logic [CNT_W-1:0]          cfg_rdata_o,
  output logic [NUM_CH-1:0]         pwm_out_o,
  output logic                      period_tick_o
);

  localparam int               CH_W        = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] c_LAST      = CNT_W'((2 ** CNT_W) - 2);
  localparam logic [1:0]       c_SEL_CTRL  = 2'd0;
  localparam logic [1:0]       c_SEL_DUTY  = 2'd1;
  localparam logic [1:0]       c_SEL_PRESC = 2'd2;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               period_tick_q, period_tick_d;
  logic [CNT_W-1:0]   rdata_q, rdata_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;

  logic               tick_w;
  logic               wrap_w;
  logic [NUM_CH-1:0]  en_out_w;
  logic [NUM_CH-1:0]  en_pwm_w;
  logic [CNT_W-1:0]   duty_sh_w  [NUM_CH];
  logic [CNT_W-1:0]   duty_act_w [NUM_CH];
  logic [CNT_W-1:0]   ctrl_rd_w;
  logic [CNT_W-1:0]   duty_rd_w;

  // Prescaler and period counter. A shrunken presc below pre_cnt restarts
  // the prescaler instead of letting it run round the full register range.
  always_comb begin
    tick_w        = (pre_cnt_q == presc_q);
    wrap_w        = tick_w && (cnt_q == c_LAST);
    period_tick_d = wrap_w;
    presc_d       = presc_q;
    pre_cnt_d     = pre_cnt_q + PRESC_W'(1);
    cnt_d         = cnt_q;
    if (tick_w || (pre_cnt_q > presc_q)) begin
      pre_cnt_d = '0;
    end
    if (wrap_w) begin
      cnt_d = '0;
    end else if (tick_w) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cfg_we_i && (cfg_sel_i == c_SEL_PRESC)) begin
      presc_d = cfg_wdata_i[PRESC_W-1:0];
    end
  end

  // Readback uses current register contents, so a coincident write is not visible.
  always_comb begin
    ctrl_rd_w = '0;
    duty_rd_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch_i == CH_W'(i)) begin
        ctrl_rd_w = CNT_W'({en_pwm_w[i], en_out_w[i]});
        duty_rd_w = duty_sh_w[i];
      end
    end
    rdata_d = rdata_q;
    if (cfg_re_i) begin
      case (cfg_sel_i)
        c_SEL_CTRL:  rdata_d = ctrl_rd_w;
        c_SEL_DUTY:  rdata_d = duty_rd_w;
        c_SEL_PRESC: rdata_d = CNT_W'(presc_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic             hit_w;
    logic             en_out_q, en_out_d;
    logic             en_pwm_q, en_pwm_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;

    assign hit_w = cfg_we_i && (cfg_ch_i == CH_W'(gi));

    always_comb begin
      en_out_d  = en_out_q;
      en_pwm_d  = en_pwm_q;
      duty_sh_d = duty_sh_q;
      if (hit_w && (cfg_sel_i == c_SEL_CTRL)) begin
        en_out_d = cfg_wdata_i[0];
        en_pwm_d = cfg_wdata_i[1];
      end
      if (hit_w && (cfg_sel_i == c_SEL_DUTY)) begin
        duty_sh_d = cfg_wdata_i;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        en_out_q  <= 1'b0;
        en_pwm_q  <= 1'b0;
        duty_sh_q <= '0;
      end else begin
        en_out_q  <= en_out_d;
        en_pwm_q  <= en_pwm_d;
        duty_sh_q <= duty_sh_d;
      end
    end

`ifdef PWM_SHADOW_EN
    // Commit takes the shadow as it was before any write on the wrap clock.
    logic [CNT_W-1:0] duty_act_q, duty_act_d;

    always_comb begin
      duty_act_d = duty_act_q;
      if (wrap_w) begin
        duty_act_d = duty_sh_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_act_q <= '0;
      end else begin
        duty_act_q <= duty_act_d;
      end
    end

    assign duty_act_w[gi] = duty_act_q;
`else
    assign duty_act_w[gi] = duty_sh_q;
`endif

    assign en_out_w[gi]  = en_out_q;
    assign en_pwm_w[gi]  = en_pwm_q;
    assign duty_sh_w[gi] = duty_sh_q;
    assign pwm_d[gi]     = en_out_q & (~en_pwm_q | (cnt_q < duty_act_w[gi]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      period_tick_q <= 1'b0;
      rdata_q       <= '0;
      pwm_q         <= '0;
    end else begin
      presc_q       <= presc_d;
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      period_tick_q <= period_tick_d;
      rdata_q       <= rdata_d;
      pwm_q         <= pwm_d;
    end
  end

  assign cfg_rdata_o   = rdata_q;
  assign pwm_out_o     = pwm_q;
  assign period_tick_o = period_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// Testbench for pwm_multi_channel: a tick/period-position model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pwm_multi_channel;

  localparam int NCH  = 16;
  localparam int MAXV = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_re;
  logic [3:0]  cfg_ch;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_wdata;
  logic [7:0]  rdata, rdata12;
  logic [15:0] pwm;
  logic [11:0] pwm12;
  logic        tick, tick12;

  always #5 clk = ~clk;

  pwm_multi_channel #(.NUM_CH(16), .CNT_W(8), .PRESC_W(4)) u_dut (
    .clk(clk), .rst(rst), .cfg_we_i(cfg_we), .cfg_re_i(cfg_re), .cfg_ch_i(cfg_ch),
    .cfg_sel_i(cfg_sel), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(rdata),
    .pwm_out_o(pwm), .period_tick_o(tick)
  );

  // Twelve-channel variant gives cfg_ch codes that lie outside the channel range.
  pwm_multi_channel #(.NUM_CH(12), .CNT_W(8), .PRESC_W(4)) u_dut12 (
    .clk(clk), .rst(rst), .cfg_we_i(cfg_we), .cfg_re_i(cfg_re), .cfg_ch_i(cfg_ch),
    .cfg_sel_i(cfg_sel), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(rdata12),
    .pwm_out_o(pwm12), .period_tick_o(tick12)
  );

  int          m_en_out[NCH], m_en_pwm[NCH], m_sh[NCH], m_act[NCH];
  int          m_presc, m_pre, m_pos;
  logic [15:0] e_pwm;
  logic        e_tick;
  logic [7:0]  e_rdata;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // m_pre = clocks since last tick, m_pos = ticks into the MAXV-tick period.
  task automatic model_step();
    int c;
    bit t, w;
    c = int'(cfg_ch);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_en_out[i] = 0; m_en_pwm[i] = 0; m_sh[i] = 0; m_act[i] = 0;
      end
      m_presc = 0; m_pre = 0; m_pos = 0;
      e_pwm = '0; e_tick = 1'b0; e_rdata = '0;
      return;
    end
    for (int i = 0; i < NCH; i++)
      e_pwm[i] = (m_en_out[i] != 0) && ((m_en_pwm[i] == 0) || (m_pos < m_act[i]));
    t = (m_pre == m_presc);
    w = t && (m_pos == MAXV - 1);
    e_tick = w;
    if (cfg_re) begin
      case (cfg_sel)
        2'd0:    e_rdata = 8'(m_en_pwm[c] * 2 + m_en_out[c]);
        2'd1:    e_rdata = 8'(m_sh[c]);
        2'd2:    e_rdata = 8'(m_presc);
        default: e_rdata = 8'h00;
      endcase
    end
    m_pre = (t || m_pre > m_presc) ? 0 : m_pre + 1;
    if (t) m_pos = (m_pos + 1) % MAXV;
`ifdef PWM_SHADOW_EN
    if (w) for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
`endif
    if (cfg_we) begin
      case (cfg_sel)
        2'd0: begin m_en_out[c] = int'(cfg_wdata[0]); m_en_pwm[c] = int'(cfg_wdata[1]); end
        2'd1: m_sh[c] = int'(cfg_wdata);
        2'd2: m_presc = int'(cfg_wdata) % 16;
        default: ;
      endcase
    end
`ifndef PWM_SHADOW_EN
    for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("model_pwm",   32'(pwm),   32'(e_pwm));
      chk("model_tick",  32'(tick),  32'(e_tick));
      chk("model_rdata", 32'(rdata), 32'(e_rdata));
    end
  end

  task automatic wr(input int ch, input int sel, input int data);
    cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_sel = 2'(sel); cfg_wdata = 8'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input int ch, input int sel);
    cfg_re = 1'b1; cfg_ch = 4'(ch); cfg_sel = 2'(sel);
    @(negedge clk);
    cfg_re = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < limit);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm[ch]) hi++;
    end
  endtask

  initial begin
    int n, hi, hi3, nz;
    rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_pwm",   32'(pwm),   0);
    chk("reset_tick",  32'(tick),  0);
    chk("reset_rdata", 32'(rdata), 0);
    chk("reset_pwm12", 32'(pwm12), 0);
    cmp_en = 1'b1;
    rst    = 1'b0;

    // en_out only: constant high, two-clock latency on and off
    wr(0, 0, 1);
    chk("ctrl01_latency", 32'(pwm[0]), 0);
    @(negedge clk);
    chk("ctrl01_on", 32'(pwm[0]), 1);
    count_high(0, 300, hi);
    chk("ctrl01_const", hi, 300);
    rd(0, 0);
    chk("ctrl01_readback", 32'(rdata), 1);
    wr(0, 0, 0);
    chk("ctrl00_hold", 32'(pwm[0]), 1);
    @(negedge clk);
    chk("ctrl00_off", 32'(pwm[0]), 0);

    // presc=0, duty 0x40: 64 of 255 clocks
    wr(3, 1, 8'h40);
    wr(3, 0, 3);
    wait_tick(600, n);
    chk("t3_sync", 32'(tick), 1);
    wait_tick(600, n);
    chk("t3_gap", n, 255);
    count_high(3, 255, hi);
    chk("t3_high", hi, 64);
    rd(3, 1);
    chk("t3_rd_duty", 32'(rdata), 8'h40);

    // presc=3 via a shrink from 15, duty 0xFF then 0x00
    wr(15, 1, 8'hFF);
    wr(15, 0, 3);
    wr(0, 2, 15);
    repeat (9) @(negedge clk);
    wr(0, 2, 3);
    rd(7, 2);
    chk("t4_rd_presc", 32'(rdata), 3);
    wait_tick(3000, n);
    chk("t4_sync", 32'(tick), 1);
    wait_tick(3000, n);
    chk("t4_gap", n, 1020);
    hi = 0; hi3 = 0;
    repeat (1020) begin
      @(negedge clk);
      if (pwm[15]) hi++;
      if (pwm[3]) hi3++;
    end
    chk("t4_ff_high", hi, 1020);
    chk("t4_ch3_high", hi3, 256);
    wr(15, 1, 0);
    wait_tick(3000, n);
    count_high(15, 1020, hi);
    chk("t4_zero_low", hi, 0);
    wr(0, 2, 0);

    // duty 0x20 -> 0xC0 written early in a period
    wr(3, 1, 8'h20);
    wait_tick(3000, n);
    chk("t5_sync", 32'(tick), 1);
    hi = 0;
    for (int j = 0; j < 255; j++) begin
      if (j == 5) begin cfg_we = 1'b1; cfg_sel = 2'd1; cfg_ch = 4'd3; cfg_wdata = 8'hC0; end
      if (j == 6) begin cfg_re = 1'b1; cfg_sel = 2'd1; cfg_ch = 4'd3; end
      @(negedge clk);
      cfg_we = 1'b0; cfg_re = 1'b0;
      if (pwm[3]) hi++;
      if (j == 6)   chk("t5_rd_immediate", 32'(rdata), 8'hC0);
      if (j == 254) chk("t5_wrap_tick", 32'(tick), 1);
    end
`ifdef PWM_SHADOW_EN
    chk("t5_first_period", hi, 32);
`else
    chk("t5_first_period", hi, 192);
`endif
    count_high(3, 255, hi);
    chk("t5_second_period", hi, 192);

    // mid-run reset with ch0 at duty 0x80
    wr(0, 1, 8'h80);
    wr(0, 0, 3);
    wait_tick(600, n);
    repeat (50) @(negedge clk);
    chk("t1_pre_reset_high", 32'(pwm[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_rst_pwm",  32'(pwm),  0);
    chk("t1_rst_tick", 32'(tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_tick(600, n);
    chk("t1_first_wrap", n, 255);
    rd(0, 0);
    chk("t1_ctrl_cleared", 32'(rdata), 0);
    rd(0, 1);
    chk("t1_duty_cleared", 32'(rdata), 0);

    // out-of-range channel and reserved select
    wr(12, 0, 3);
    wr(12, 1, 8'hFF);
    wr(5, 3, 8'h55);
    nz = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm12 != '0) nz++;
    end
    chk("t6_oor_no_output", nz, 0);
    rd(12, 0);
    chk("t6_oor_rd_ctrl", 32'(rdata12), 0);
    chk("t6_inrange_rd_ctrl", 32'(rdata), 3);
    rd(12, 1);
    chk("t6_oor_rd_duty", 32'(rdata12), 0);
    rd(5, 3);
    chk("t6_sel3_rd", 32'(rdata), 0);
    wr(11, 0, 1);
    @(negedge clk);
    chk("t6_dut12_ch11", 32'(pwm12[11]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
